// File: rtl/fsm_code_pkg.sv
// Shared definitions for the y-code tracker: sender state and code values,
// tracker FSM encodings and the sender's legal transition graph.
package fsm_code_pkg;

   localparam logic [1:0] ST0 = 2'd0;
   localparam logic [1:0] ST1 = 2'd1;
   localparam logic [1:0] ST2 = 2'd2;
   localparam logic [1:0] ST3 = 2'd3;

   localparam logic [2:0] CODE_ST0 = 3'd1;
   localparam logic [2:0] CODE_ST1 = 3'd2;
   localparam logic [2:0] CODE_ST2 = 3'd3;
   localparam logic [2:0] CODE_ST3 = 3'd4;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      TRAIN  = 2'd1,
      LOCKED = 2'd2
   } trk_state_t;

   // Only ST1 branches; control is the value the sender presented with its ST1 code.
   function automatic logic [1:0] next_state(input logic [1:0] state, input logic control);
      logic [1:0] nxt;
      case (state)
         ST0:     nxt = ST1;
         ST1:     nxt = control ? ST2 : ST3;
         ST2:     nxt = ST3;
         ST3:     nxt = ST0;
         default: nxt = ST0;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/fsm_code_tracker_sat_counter.sv
// Saturating up-counter with a synchronous load-on-clear, used for the
// tracker's error and loop statistics.
module sat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             inc,
   input  logic             clr,
   input  logic [WIDTH-1:0] clr_val,
   output logic [WIDTH-1:0] count
);

   localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

   logic [WIDTH-1:0] count_r;

   // Clear wins over increment; the clear value lets a coinciding event still be counted.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_r <= {WIDTH{1'b0}};
      end else if (clr) begin
         count_r <= clr_val;
      end else if (inc && (count_r != CNT_MAX)) begin
         count_r <= count_r + CNT_ONE;
      end
   end

   assign count = count_r;

endmodule

// File: rtl/fsm_code_tracker.sv
// Receive-side monitor that regenerates the 4-state controller's state from its
// y code stream, checks each step against the legal graph and reports lock/errors.
module fsm_code_tracker
   import fsm_code_pkg::*;
#(
   parameter int LOCK_LEN = 3,
   parameter int CNT_W    = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             code_valid,
   input  logic [2:0]       code,
   input  logic             control,
   input  logic             clr_counts,
   output logic [1:0]       state_out,
   output logic             locked,
   output logic             err_pulse,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] loop_count
);

   localparam logic [3:0] LOCK_RUN = 4'(LOCK_LEN);

   trk_state_t       trk_r, trk_next;
   logic [1:0]       state_r, state_next;
   logic [3:0]       run_r, run_next, run_inc_s;
   logic             ctl_r;
   logic             locked_r, err_pulse_r;
   logic             code_legal_s;
   logic [1:0]       code_st_s;
   logic             is_hold_s, is_succ_s;
   logic             err_s, loop_inc_s;
   logic [CNT_W-1:0] err_clr_val_s;

   // Decode the observed code into a sender state and a legality flag.
   always_comb begin
      code_legal_s = 1'b1;
      code_st_s    = ST0;
      case (code)
         CODE_ST0: code_st_s = ST0;
         CODE_ST1: code_st_s = ST1;
         CODE_ST2: code_st_s = ST2;
         CODE_ST3: code_st_s = ST3;
         default: begin
            code_legal_s = 1'b0;
            code_st_s    = ST0;
         end
      endcase
   end

   assign is_hold_s = code_legal_s && (code_st_s == state_r);
   assign is_succ_s = code_legal_s && (code_st_s == next_state(state_r, ctl_r));
   assign run_inc_s = run_r + 4'd1;

   // Tracker next-state: holds are always legal; only successors advance the run.
   always_comb begin
      trk_next   = trk_r;
      state_next = state_r;
      run_next   = run_r;
      err_s      = 1'b0;
      loop_inc_s = 1'b0;
      if (code_valid) begin
         case (trk_r)
            HUNT: begin
               if (code_legal_s) begin
                  state_next = code_st_s;
                  run_next   = 4'd0;
                  trk_next   = TRAIN;
               end else begin
                  trk_next = HUNT;
               end
            end
            TRAIN: begin
               if (is_hold_s) begin
                  trk_next = TRAIN;
               end else if (is_succ_s) begin
                  state_next = code_st_s;
                  run_next   = run_inc_s;
                  if (run_inc_s == LOCK_RUN) begin
                     trk_next = LOCKED;
                  end else begin
                     trk_next = TRAIN;
                  end
               end else begin
                  run_next = 4'd0;
                  trk_next = HUNT;
               end
            end
            LOCKED: begin
               if (is_hold_s) begin
                  trk_next = LOCKED;
               end else if (is_succ_s) begin
                  state_next = code_st_s;
                  loop_inc_s = (state_r == ST3);
               end else begin
                  err_s    = 1'b1;
                  run_next = 4'd0;
                  trk_next = HUNT;
               end
            end
            default: begin
               run_next = 4'd0;
               trk_next = HUNT;
            end
         endcase
      end else begin
         trk_next = trk_r;
      end
   end

   // Tracker state and registered outputs; control is captured with every valid code.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         trk_r       <= HUNT;
         state_r     <= ST0;
         run_r       <= 4'd0;
         ctl_r       <= 1'b0;
         locked_r    <= 1'b0;
         err_pulse_r <= 1'b0;
      end else begin
         trk_r       <= trk_next;
         state_r     <= state_next;
         run_r       <= run_next;
         locked_r    <= (trk_next == LOCKED);
         err_pulse_r <= err_s;
         if (code_valid) begin
            ctl_r <= control;
         end
      end
   end

   assign err_clr_val_s = CNT_W'(err_s);

   sat_counter #(.WIDTH(CNT_W)) u_err_count (
      .clock   (clock),
      .reset   (reset),
      .inc     (err_s),
      .clr     (clr_counts),
      .clr_val (err_clr_val_s),
      .count   (err_count)
   );

   sat_counter #(.WIDTH(CNT_W)) u_loop_count (
      .clock   (clock),
      .reset   (reset),
      .inc     (loop_inc_s),
      .clr     (clr_counts),
      .clr_val ({CNT_W{1'b0}}),
      .count   (loop_count)
   );

   assign state_out = state_r;
   assign locked    = locked_r;
   assign err_pulse = err_pulse_r;

endmodule

// File: tb/tb_fsm_code_tracker.sv
// Bench for fsm_code_tracker: directed scenarios then randomized code streams,
// two DUT widths driven in parallel and checked against a behavioural model.
module tb_fsm_code_tracker;

   localparam int LOCK_LEN = 3;
   localparam int MAX8 = 255;
   localparam int MAX2 = 3;
   localparam int M_HUNT = 0, M_TRAIN = 1, M_LOCKED = 2;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       code_valid = 1'b0;
   logic [2:0] code = 3'd0;
   logic       control = 1'b0;
   logic       clr_counts = 1'b0;

   logic [1:0] state8, state2;
   logic       locked8, locked2, errp8, errp2;
   logic [7:0] err8, loop8;
   logic [1:0] err2, loop2;

   int n_vec = 0;
   int n_miss = 0;

   // model state
   int m_mode, m_so, m_run, m_ctl, m_errp, m_err8, m_loop8, m_err2, m_loop2;

   always #5 clock = ~clock;

   fsm_code_tracker #(.LOCK_LEN(LOCK_LEN), .CNT_W(8)) dut8 (
      .clock(clock), .reset(reset), .code_valid(code_valid), .code(code),
      .control(control), .clr_counts(clr_counts), .state_out(state8),
      .locked(locked8), .err_pulse(errp8), .err_count(err8), .loop_count(loop8)
   );

   fsm_code_tracker #(.LOCK_LEN(LOCK_LEN), .CNT_W(2)) dut2 (
      .clock(clock), .reset(reset), .code_valid(code_valid), .code(code),
      .control(control), .clr_counts(clr_counts), .state_out(state2),
      .locked(locked2), .err_pulse(errp2), .err_count(err2), .loop_count(loop2)
   );

   task automatic check_value(input string tag, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_miss++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int succ(input int st, input int ctl);
      if (st == 1 && ctl == 0) return 3;
      return (st + 1) % 4;
   endfunction

   function automatic int sat_add(input int v, input int inc, input int mx);
      return (v + inc > mx) ? mx : v + inc;
   endfunction

   task automatic model_reset();
      m_mode = M_HUNT; m_so = 0; m_run = 0; m_ctl = 0; m_errp = 0;
      m_err8 = 0; m_loop8 = 0; m_err2 = 0; m_loop2 = 0;
   endtask

   task automatic model_step(input int v, input int c, input int ctl, input int clr);
      int legal, cs, err, lp;
      err = 0; lp = 0;
      legal = (c >= 1 && c <= 4);
      cs = c - 1;
      if (v != 0) begin
         if (m_mode == M_HUNT) begin
            if (legal != 0) begin m_so = cs; m_run = 0; m_mode = M_TRAIN; end
         end else if (legal != 0 && cs == m_so) begin
            // sender holding its state: nothing changes
         end else if (legal != 0 && cs == succ(m_so, m_ctl)) begin
            if (m_mode == M_LOCKED) begin
               lp = (m_so == 3) ? 1 : 0;
            end else begin
               m_run = m_run + 1;
               if (m_run == LOCK_LEN) m_mode = M_LOCKED;
            end
            m_so = cs;
         end else begin
            err = (m_mode == M_LOCKED) ? 1 : 0;
            m_mode = M_HUNT; m_run = 0;
         end
         m_ctl = ctl;
      end
      m_errp = err;
      if (clr != 0) begin
         m_err8 = err; m_err2 = err; m_loop8 = 0; m_loop2 = 0;
      end else begin
         m_err8 = sat_add(m_err8, err, MAX8); m_err2 = sat_add(m_err2, err, MAX2);
         m_loop8 = sat_add(m_loop8, lp, MAX8); m_loop2 = sat_add(m_loop2, lp, MAX2);
      end
   endtask

   task automatic compare_all();
      check_value("state_out", int'(state8), m_so);
      check_value("state_out_w2", int'(state2), m_so);
      check_value("locked", int'(locked8), (m_mode == M_LOCKED) ? 1 : 0);
      check_value("err_pulse", int'(errp8), m_errp);
      check_value("err_count", int'(err8), m_err8);
      check_value("loop_count", int'(loop8), m_loop8);
      check_value("err_count_w2", int'(err2), m_err2);
      check_value("loop_count_w2", int'(loop2), m_loop2);
   endtask

   task automatic apply(input int v, input int c, input int ctl, input int clr);
      @(negedge clock);
      code_valid = (v != 0); code = 3'(c); control = (ctl != 0); clr_counts = (clr != 0);
      @(posedge clock);
      model_step(v, c, ctl, clr);
      #1;
      compare_all();
   endtask

   // Reset is raised away from the clock edge so the clear must be asynchronous.
   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1; code_valid = 1'b0; clr_counts = 1'b0;
      #1;
      model_reset();
      compare_all();
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic lock_up();
      apply(1, 1, 0, 0); apply(1, 2, 1, 0); apply(1, 3, 0, 0); apply(1, 4, 0, 0);
   endtask

   initial begin
      int snd, sctl, v, c, ctl, p;
      model_reset();
      do_reset();

      // 1: clean run, lock after the fourth code, one wrap
      lock_up();
      check_value("t1_locked", int'(locked8), 1);
      apply(1, 1, 0, 0);
      check_value("t1_loop", int'(loop8), 1);

      // 2: ST1 with control 0 only permits ST3
      apply(1, 2, 0, 0);
      apply(1, 3, 0, 0);
      check_value("t2_err_pulse", int'(errp8), 1);
      check_value("t2_unlocked", int'(locked8), 0);
      apply(0, 0, 0, 0);
      check_value("t2_pulse_width", int'(errp8), 0);

      // 3: repeated ST1 with gaps while locked
      lock_up(); apply(1, 1, 0, 0);
      for (int i = 0; i < 5; i++) begin apply(1, 2, 1, 0); apply(0, 5, 0, 0); end
      check_value("t3_state", int'(state8), 1);
      check_value("t3_locked", int'(locked8), 1);

      // 4: illegal codes in HUNT and TRAIN are silent
      do_reset();
      apply(1, 6, 0, 0); apply(1, 1, 0, 0); apply(1, 6, 0, 0);
      apply(1, 2, 1, 0); apply(1, 3, 0, 0); apply(1, 4, 0, 0);
      check_value("t4_not_locked", int'(locked8), 0);
      apply(1, 1, 0, 0);
      check_value("t4_err_zero", int'(err8), 0);
      check_value("t4_locked", int'(locked8), 1);

      // 5: saturation of the narrow error counter, then error coinciding with clear
      do_reset();
      for (int i = 0; i < 5; i++) begin lock_up(); apply(1, 6, 0, 0); end
      check_value("t5_sat", int'(err2), 3);
      lock_up(); apply(1, 7, 0, 1);
      check_value("t5_clr_err", int'(err2), 1);

      // 6: reset while locked at ST2; next code 4 is a fresh HUNT code
      do_reset();
      lock_up(); apply(1, 1, 0, 0); apply(1, 2, 1, 0); apply(1, 3, 0, 0);
      do_reset();
      apply(1, 4, 0, 0);
      check_value("t6_no_err", int'(errp8), 0);
      check_value("t6_state", int'(state8), 3);

      // randomized sender with holds, gaps, corruptions, clears and resets
      snd = 3; sctl = 0;
      for (int i = 0; i < 3000; i++) begin
         v = ($urandom_range(99) < 85) ? 1 : 0;
         ctl = int'($urandom_range(1));
         p = int'($urandom_range(99));
         if (p < 72) c = succ(snd, sctl) + 1;
         else if (p < 88) c = snd + 1;
         else c = int'($urandom_range(7));
         if (v != 0 && c >= 1 && c <= 4) begin snd = c - 1; sctl = ctl; end
         apply(v, c, ctl, ($urandom_range(99) < 3) ? 1 : 0);
         if ($urandom_range(499) == 0) do_reset();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
